// File: rtl/uart_lock_status_tx.sv
// uart_lock_status_tx: 8N1 UART that sends "OPEN"/"CLOSED" whenever lock_open differs from the last reported state
//   clk       system clock
//   rst       synchronous active-low reset
//   lock_open lock state level (1 = open)
//   tx_pin    registered serial output, idles high
//   tx_busy   high while a message is shifting out
//   msg_done  one-cycle pulse after the final stop bit of a message
//   Define LOCK_TX_CRLF_EN to append "\r\n" to every message.
module uart_lock_status_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic lock_open,
  output logic tx_pin,
  output logic tx_busy,
  output logic msg_done
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
`ifdef LOCK_TX_CRLF_EN
  localparam logic [63:0] OPEN_S   = 64'h0000_0A0D_4E45_504F;
  localparam logic [63:0] CLOSED_S = 64'h0A0D_4445_534F_4C43;
  localparam logic [2:0]  OPEN_LAST   = 3'd5;
  localparam logic [2:0]  CLOSED_LAST = 3'd7;
`else
  localparam logic [63:0] OPEN_S   = 64'h0000_0000_4E45_504F;
  localparam logic [63:0] CLOSED_S = 64'h0000_4445_534F_4C43;
  localparam logic [2:0]  OPEN_LAST   = 3'd3;
  localparam logic [2:0]  CLOSED_LAST = 3'd5;
`endif
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bi;
  logic [2:0]       ci;
  logic [7:0]       sh;
  logic             sel;
  logic             reported;
  logic [63:0]      msg;
  logic [7:0]       ch;
  logic [2:0]       last;
  logic             bit_end;
  // Character 0 sits in the low byte of each packed string.
  assign msg     = sel ? OPEN_S : CLOSED_S;
  assign ch      = msg[{ci, 3'b000} +: 8];
  assign last    = sel ? OPEN_LAST : CLOSED_LAST;
  assign bit_end = cnt == CNT_W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bi       <= '0;
      ci       <= '0;
      sh       <= '0;
      sel      <= 1'b0;
      reported <= 1'b0;
      tx_pin   <= 1'b1;
      tx_busy  <= 1'b0;
      msg_done <= 1'b0;
    end else begin
      msg_done <= 1'b0;
      cnt      <= (state == IDLE || bit_end) ? '0 : cnt + CNT_W'(1);
      case (state)
        IDLE: if (lock_open != reported) begin
          sel      <= lock_open;
          reported <= lock_open;
          ci       <= '0;
          state    <= START;
          tx_pin   <= 1'b0;
          tx_busy  <= 1'b1;
        end
        START: if (bit_end) begin
          state  <= DATA;
          bi     <= '0;
          tx_pin <= ch[0];
          sh     <= {1'b0, ch[7:1]};
        end
        DATA: if (bit_end) begin
          state  <= (bi == 3'd7) ? STOP : DATA;
          tx_pin <= (bi == 3'd7) ? 1'b1 : sh[0];
          sh     <= {1'b0, sh[7:1]};
          bi     <= bi + 3'd1;
        end
        STOP: if (bit_end) begin
          if (ci == last) begin
            state    <= IDLE;
            tx_busy  <= 1'b0;
            msg_done <= 1'b1;
          end else begin
            ci     <= ci + 3'd1;
            state  <= START;
            tx_pin <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_lock_status_tx.sv
// tb_uart_lock_status_tx: cycle-exact directed checks of the lock status transmitter
module tb_uart_lock_status_tx;
  localparam int C = 4;
`ifdef LOCK_TX_CRLF_EN
  localparam logic [63:0] OPEN_S   = 64'h0000_0A0D_4E45_504F;
  localparam logic [63:0] CLOSED_S = 64'h0A0D_4445_534F_4C43;
  localparam int OL = 6;
  localparam int CL = 8;
`else
  localparam logic [63:0] OPEN_S   = 64'h0000_0000_4E45_504F;
  localparam logic [63:0] CLOSED_S = 64'h0000_4445_534F_4C43;
  localparam int OL = 4;
  localparam int CL = 6;
`endif
  logic clk = 1'b0;
  logic rst;
  logic lock_open;
  logic tx_pin;
  logic tx_busy;
  logic msg_done;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  uart_lock_status_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .rst(rst),
    .lock_open(lock_open),
    .tx_pin(tx_pin),
    .tx_busy(tx_busy),
    .msg_done(msg_done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic idle_check(input string tag, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ({tx_pin, tx_busy, msg_done} !== 3'b100) bad++;
    end
    chk(tag, bad, 0);
  endtask
  // Call right after lock_open is driven to a mismatching value on a negedge,
  // or right after a previous message's msg_done cycle when the mismatch persists.
  // Checks {tx_pin, tx_busy, msg_done} on every cycle from E+1 to the msg_done cycle.
  task automatic run_msg(input string tag, input logic [63:0] s, input int len,
                         input int t_set, input logic v_set,
                         input int t_back, input logic v_back);
    int total = 10 * len * C;
    for (int t = 1; t <= total + 1; t++) begin
      logic [2:0] exp;
      logic [7:0] by;
      @(negedge clk);
      if (t <= total) begin
        int b = (t - 1) / C;
        int n = b / 10;
        int k = b % 10;
        by  = s[n * 8 +: 8];
        exp = {(k == 0) ? 1'b0 : (k == 9) ? 1'b1 : by[k - 1], 2'b10};
      end else begin
        exp = 3'b101;
      end
      chk(tag, {29'd0, tx_pin, tx_busy, msg_done}, {29'd0, exp});
      if (t == t_set) lock_open = v_set;
      if (t == t_back) lock_open = v_back;
    end
  endtask
  initial begin
    rst = 1'b0;
    lock_open = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset", {29'd0, tx_pin, tx_busy, msg_done}, 32'b100);
    rst = 1'b1;
    idle_check("idle_1000", 1000);
    lock_open = 1'b1;
    run_msg("open", OPEN_S, OL, 0, 1'b0, 0, 1'b0);
    idle_check("post_open", 20);
    lock_open = 1'b0;
    run_msg("closed", CLOSED_S, CL, 0, 1'b0, 0, 1'b0);
    lock_open = 1'b1;
    run_msg("open_pulse", OPEN_S, OL, 50, 1'b0, 60, 1'b1);
    idle_check("no_retx", 500);
    lock_open = 1'b0;
    run_msg("closed2", CLOSED_S, CL, 0, 1'b0, 0, 1'b0);
    idle_check("gap", 5);
    lock_open = 1'b1;
    run_msg("open_hold", OPEN_S, OL, 100, 1'b0, 0, 1'b0);
    run_msg("closed_chain", CLOSED_S, CL, 0, 1'b0, 0, 1'b0);
    idle_check("post_chain", 20);
    lock_open = 1'b1;
    repeat (57) @(negedge clk);
    chk("char1_bit3", {31'd0, tx_pin}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort", {29'd0, tx_pin, tx_busy, msg_done}, 32'b100);
    rst = 1'b1;
    run_msg("open_after_rst", OPEN_S, OL, 0, 1'b0, 0, 1'b0);
    idle_check("final_idle", 50);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
